fwd_hazard_unit: RTL and testbench

//  Parametrised successor to the single-entry hazard detector. Sits between decode/EX
//  and the RAM/GPR writeback path. Tracks the last FWD_DEPTH register writes in a

---
 rtl/fwd_hazard_unit.sv | 131 +++++++++++++
 tb/tb_fwd_hazard_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and hazard control: a FWD_DEPTH-deep write history feeds
// per-source forwarding, plus load-use stall, store stall and branch flush windows.
module fwd_hazard_unit #(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 3,
  parameter int STORE_CYC = 1,
  parameter int FLUSH_CYC = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ex_wr_en,
  input  logic [REG_AW-1:0]         ex_wr_dst,
  input  logic [DATA_W-1:0]         ex_wr_data,
  input  logic                      ex_is_load,
  input  logic [DATA_W-1:0]         mem_rd_data,
  input  logic [NUM_SRC*REG_AW-1:0] src_tag,
  output logic [NUM_SRC-1:0]        src_fwd_sel,
  output logic [NUM_SRC*DATA_W-1:0] src_fwd_data,
  input  logic                      store_req,
  input  logic                      branch_taken,
  output logic                      stall,
  output logic                      flush
);

  localparam int CW = 4;

  logic [FWD_DEPTH-1:0] h_valid_r;
  logic [FWD_DEPTH-1:0] h_pend_r;
  logic [REG_AW-1:0]    h_dst_r  [FWD_DEPTH];
  logic [DATA_W-1:0]    h_data_r [FWD_DEPTH];
  logic [CW-1:0]        st_cnt_r;
  logic [CW-1:0]        fl_cnt_r;

  logic [NUM_SRC-1:0]        hit_s;
  logic [NUM_SRC-1:0]        fwd_sel_s;
  logic [NUM_SRC*DATA_W-1:0] fwd_data_s;
  logic                      load_use_s;
  logic                      flush_s;
  logic                      stall_s;

  // Youngest-first lookup per source; a pending youngest hit means load-use.
  always_comb begin
    hit_s      = '0;
    fwd_sel_s  = '0;
    fwd_data_s = '0;
    load_use_s = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int i = 0; i < FWD_DEPTH; i++) begin
        if (!hit_s[s] && h_valid_r[i] &&
            (src_tag[s*REG_AW +: REG_AW] != '0) &&
            (h_dst_r[i] == src_tag[s*REG_AW +: REG_AW])) begin
          hit_s[s] = 1'b1;
          if (h_pend_r[i]) begin
            load_use_s = 1'b1;
          end else begin
            fwd_sel_s[s]                     = 1'b1;
            fwd_data_s[s*DATA_W +: DATA_W]   = h_data_r[i];
          end
        end else begin
          hit_s[s] = hit_s[s];
        end
      end
    end
  end

  assign flush_s      = (fl_cnt_r != '0);
  assign stall_s      = (load_use_s | (st_cnt_r != '0)) & ~flush_s;
  assign stall        = stall_s;
  assign flush        = flush_s;
  assign src_fwd_sel  = fwd_sel_s;
  assign src_fwd_data = fwd_data_s;

  // Write history shift register; a pending load picks up RAM data as it ages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_valid_r <= '0;
      h_pend_r  <= '0;
      for (int i = 0; i < FWD_DEPTH; i++) begin
        h_dst_r[i]  <= '0;
        h_data_r[i] <= '0;
      end
    end else begin
      if (stall_s || flush_s) begin
        h_valid_r[0] <= 1'b0;
        h_pend_r[0]  <= 1'b0;
        h_dst_r[0]   <= '0;
        h_data_r[0]  <= '0;
      end else begin
        h_valid_r[0] <= ex_wr_en;
        h_pend_r[0]  <= ex_is_load & ex_wr_en;
        h_dst_r[0]   <= ex_wr_dst;
        h_data_r[0]  <= ex_wr_data;
      end
      for (int i = 1; i < FWD_DEPTH; i++) begin
        h_valid_r[i] <= h_valid_r[i-1];
        h_pend_r[i]  <= 1'b0;
        h_dst_r[i]   <= h_dst_r[i-1];
        h_data_r[i]  <= h_pend_r[i-1] ? mem_rd_data : h_data_r[i-1];
      end
    end
  end

  // Store window: non-extending, and a store racing a taken branch is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_cnt_r <= '0;
    end else if (st_cnt_r != '0) begin
      st_cnt_r <= st_cnt_r - 4'd1;
    end else if (store_req && !branch_taken) begin
      st_cnt_r <= CW'(STORE_CYC);
    end else begin
      st_cnt_r <= '0;
    end
  end

  // Flush window: every taken branch restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fl_cnt_r <= '0;
    end else if (branch_taken) begin
      fl_cnt_r <= CW'(FLUSH_CYC);
    end else if (fl_cnt_r != '0) begin
      fl_cnt_r <= fl_cnt_r - 4'd1;
    end else begin
      fl_cnt_r <= '0;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit with STORE_CYC=2, FLUSH_CYC=2, FWD_DEPTH=3.
module tb_fwd_hazard_unit;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int NS     = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ex_wr_en, ex_is_load, store_req, branch_taken;
  logic [REG_AW-1:0] ex_wr_dst;
  logic [DATA_W-1:0] ex_wr_data, mem_rd_data;
  logic [NS*REG_AW-1:0] src_tag;
  logic [NS-1:0]        src_fwd_sel;
  logic [NS*DATA_W-1:0] src_fwd_data;
  logic stall, flush;

  int vec  = 0;
  int miss = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_SRC(NS), .FWD_DEPTH(3),
                    .STORE_CYC(2), .FLUSH_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .ex_wr_en(ex_wr_en), .ex_wr_dst(ex_wr_dst),
    .ex_wr_data(ex_wr_data), .ex_is_load(ex_is_load), .mem_rd_data(mem_rd_data),
    .src_tag(src_tag), .src_fwd_sel(src_fwd_sel), .src_fwd_data(src_fwd_data),
    .store_req(store_req), .branch_taken(branch_taken), .stall(stall), .flush(flush));

  task automatic idle();
    ex_wr_en = 1'b0; ex_wr_dst = '0; ex_wr_data = '0; ex_is_load = 1'b0;
    mem_rd_data = '0; src_tag = '0; store_req = 1'b0; branch_taken = 1'b0;
  endtask

  // Advance one cycle; inputs are then driven 1 time unit after the edge.
  task automatic step();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #3;
    vec++; if (stall !== 1'b0) begin miss++; $display("FAIL reset_stall got %b exp 0", stall); end
    vec++; if (flush !== 1'b0) begin miss++; $display("FAIL reset_flush got %b exp 0", flush); end
    src_tag = {5'd1, 5'd1}; #1;
    vec++; if (src_fwd_sel !== 2'b00) begin miss++; $display("FAIL reset_sel got %b exp 00", src_fwd_sel); end
    vec++; if (src_fwd_data !== 64'd0) begin miss++; $display("FAIL reset_data got %h exp 0", src_fwd_data); end
    @(negedge clk); rst_n = 1'b1;
    step();
  endtask

  task automatic test_forward_age();
    ex_wr_en = 1'b1; ex_wr_dst = 5'd5; ex_wr_data = 32'hA5;
    step();
    src_tag = {5'd0, 5'd5}; #1;
    vec++; if (src_fwd_sel[0] !== 1'b1) begin miss++; $display("FAIL fwd_sel got %b exp 1", src_fwd_sel[0]); end
    vec++; if (src_fwd_data[31:0] !== 32'hA5) begin miss++; $display("FAIL fwd_data got %h exp a5", src_fwd_data[31:0]); end
    step(); step(); step();
    src_tag = {5'd0, 5'd5}; #1;
    vec++; if (src_fwd_sel[0] !== 1'b0) begin miss++; $display("FAIL fwd_aged_out got %b exp 0", src_fwd_sel[0]); end
  endtask

  task automatic test_youngest_and_zero();
    ex_wr_en = 1'b1; ex_wr_dst = 5'd7; ex_wr_data = 32'h11;
    step();
    ex_wr_en = 1'b1; ex_wr_dst = 5'd7; ex_wr_data = 32'h22;
    step();
    src_tag = {5'd7, 5'd0}; #1;
    vec++; if (src_fwd_sel !== 2'b10) begin miss++; $display("FAIL young_sel got %b exp 10", src_fwd_sel); end
    vec++; if (src_fwd_data[63:32] !== 32'h22) begin miss++; $display("FAIL young_data got %h exp 22", src_fwd_data[63:32]); end
    vec++; if (src_fwd_data[31:0] !== 32'h0) begin miss++; $display("FAIL zero_tag_data got %h exp 0", src_fwd_data[31:0]); end
    step();
  endtask

  task automatic test_load_use();
    ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_wr_dst = 5'd3; ex_wr_data = 32'hDEAD;
    step();
    mem_rd_data = 32'hBEEF; src_tag = {5'd0, 5'd3}; #1;
    vec++; if (stall !== 1'b1) begin miss++; $display("FAIL lu_stall got %b exp 1", stall); end
    vec++; if (src_fwd_sel[0] !== 1'b0) begin miss++; $display("FAIL lu_sel got %b exp 0", src_fwd_sel[0]); end
    step();
    src_tag = {5'd3, 5'd3}; #1;
    vec++; if (stall !== 1'b0) begin miss++; $display("FAIL lu_release got %b exp 0", stall); end
    vec++; if (src_fwd_sel !== 2'b11) begin miss++; $display("FAIL lu_fill_sel got %b exp 11", src_fwd_sel); end
    vec++; if (src_fwd_data !== {32'hBEEF, 32'hBEEF}) begin miss++; $display("FAIL lu_fill_data got %h exp beef", src_fwd_data); end
    step(); step(); step();
  endtask

  task automatic test_store_window();
    store_req = 1'b1; #1;
    vec++; if (stall !== 1'b0) begin miss++; $display("FAIL st_t0 got %b exp 0", stall); end
    step();
    store_req = 1'b1; #1;
    vec++; if (stall !== 1'b1) begin miss++; $display("FAIL st_t1 got %b exp 1", stall); end
    step(); #1;
    vec++; if (stall !== 1'b1) begin miss++; $display("FAIL st_t2 got %b exp 1", stall); end
    step(); #1;
    vec++; if (stall !== 1'b0) begin miss++; $display("FAIL st_t3 got %b exp 0", stall); end
    step();
  endtask

  task automatic test_back_to_back_branch_store();
    branch_taken = 1'b1; store_req = 1'b1;
    step();
    ex_wr_en = 1'b1; ex_wr_dst = 5'd9; ex_wr_data = 32'h99; #1;
    vec++; if (flush !== 1'b1) begin miss++; $display("FAIL br_flush1 got %b exp 1", flush); end
    vec++; if (stall !== 1'b0) begin miss++; $display("FAIL br_stall1 got %b exp 0", stall); end
    step();
    ex_wr_en = 1'b1; ex_wr_dst = 5'd9; ex_wr_data = 32'h99; #1;
    vec++; if (flush !== 1'b1) begin miss++; $display("FAIL br_flush2 got %b exp 1", flush); end
    vec++; if (stall !== 1'b0) begin miss++; $display("FAIL br_stall2 got %b exp 0", stall); end
    step();
    src_tag = {5'd0, 5'd9}; #1;
    vec++; if (flush !== 1'b0) begin miss++; $display("FAIL br_flush_end got %b exp 0", flush); end
    vec++; if (stall !== 1'b0) begin miss++; $display("FAIL br_store_dropped got %b exp 0", stall); end
    vec++; if (src_fwd_sel[0] !== 1'b0) begin miss++; $display("FAIL br_bubble got %b exp 0", src_fwd_sel[0]); end
    step(); step(); step();
  endtask

  task automatic test_reset_mid_window();
    branch_taken = 1'b1; ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_wr_dst = 5'd4;
    step();
    src_tag = {5'd4, 5'd4}; #1;
    vec++; if (flush !== 1'b1) begin miss++; $display("FAIL rst_pre_flush got %b exp 1", flush); end
    rst_n = 1'b0; #1;
    vec++; if (flush !== 1'b0) begin miss++; $display("FAIL rst_flush got %b exp 0", flush); end
    vec++; if (stall !== 1'b0) begin miss++; $display("FAIL rst_stall got %b exp 0", stall); end
    @(negedge clk); rst_n = 1'b1;
    step();
    src_tag = {5'd4, 5'd4}; mem_rd_data = 32'h1234; #1;
    vec++; if (src_fwd_sel !== 2'b00) begin miss++; $display("FAIL rst_sel got %b exp 00", src_fwd_sel); end
    vec++; if (stall !== 1'b0) begin miss++; $display("FAIL rst_no_pending got %b exp 0", stall); end
    step();
  endtask

  initial begin
    test_reset();
    test_forward_age();
    test_youngest_and_zero();
    test_load_use();
    test_store_window();
    test_back_to_back_branch_store();
    test_reset_mid_window();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
